// File: rtl/seg7_io_display_pkg.sv
// rtl/seg7_io_display_pkg.sv - shared constants and glyph table for the seven-segment display block
package seg7_io_display_pkg;

    localparam logic [3:0] ADDR_DATA_DEF = 4'hC;
    localparam logic [3:0] ADDR_CTRL_DEF = 4'hD;

    localparam int CTRL_EN_LSB     = 0;
    localparam int CTRL_BLANK_BIT  = 4;
    localparam int CTRL_BRIGHT_LSB = 5;

    localparam logic [7:0] CTRL_RESET = 8'hEF;
    localparam logic [3:0] AN_RESET   = 4'b1110;
    localparam logic [6:0] LED_RESET  = 7'b1000000;
    localparam logic [6:0] LED_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef struct packed {
        logic [2:0] bright;
        logic       blank_lz;
        logic [3:0] digit_en;
    } ctrl_t;

    // gfedcba, active-high; entry n is the glyph for nibble n
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - nibble to active-high seven-segment glyph
module seg7_hex_decoder
    import seg7_io_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPHS[nibble_i];

endmodule

// File: rtl/seg7_io_display.sv
// rtl/seg7_io_display.sv - memory-mapped 4-digit multiplexed seven-segment display controller
module seg7_io_display
    import seg7_io_display_pkg::*;
#(
    parameter int         REFRESH_BITS = 16,
    parameter logic [3:0] ADDR_DATA    = ADDR_DATA_DEF,
    parameter logic [3:0] ADDR_CTRL    = ADDR_CTRL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  io_addr,
    input  logic [31:0] io_write_data,
    input  logic        io_write_en,
    output logic [31:0] io_read_data,
    output logic [6:0]  LED,
    output logic [3:0]  AN
);

    logic [15:0]             data_q, data_d;
    logic [7:0]              ctrl_q, ctrl_d;
    logic [REFRESH_BITS-1:0] cnt_q;
    logic [3:0]              an_q, an_d;
    logic [6:0]              led_q, led_d;

    ctrl_t      ctrl_f;
    logic [1:0] sel;
    logic [2:0] pwm;
    logic [3:0] nibble;
    logic [6:0] glyph;
    logic       nonzero_above;
    logic       lit;
    logic       unused_wdata;

    assign unused_wdata = ^io_write_data[31:16];
    assign ctrl_f       = ctrl_q;
    assign sel          = cnt_q[REFRESH_BITS-1 -: 2];
    assign pwm          = cnt_q[2:0];
    assign nibble       = data_q[{sel, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (nibble),
        .glyph_o  (glyph)
    );

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (io_write_en && io_addr == ADDR_DATA) data_d = io_write_data[15:0];
        if (io_write_en && io_addr == ADDR_CTRL) ctrl_d = io_write_data[7:0];
    end

    always_comb begin
        io_read_data = 32'd0;
        if (io_addr == ADDR_DATA)      io_read_data = {16'd0, data_q};
        else if (io_addr == ADDR_CTRL) io_read_data = {24'd0, ctrl_q};
    end

    // Leading-zero blanking looks at the selected nibble and everything above it
    always_comb begin
        case (sel)
            2'd0:    nonzero_above = 1'b1;
            2'd1:    nonzero_above = |data_q[15:4];
            2'd2:    nonzero_above = |data_q[15:8];
            default: nonzero_above = |data_q[15:12];
        endcase
        lit = ctrl_f.digit_en[sel]
            && (!ctrl_f.blank_lz || nonzero_above)
            && (pwm <= ctrl_f.bright);
        an_d  = lit ? ~(4'b0001 << sel) : AN_OFF;
        led_d = lit ? ~glyph : LED_OFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= 16'h0000;
            ctrl_q <= CTRL_RESET;
            cnt_q  <= '0;
            an_q   <= AN_RESET;
            led_q  <= LED_RESET;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_q + 1'b1;
            an_q   <= an_d;
            led_q  <= led_d;
        end
    end

    assign AN  = an_q;
    assign LED = led_q;

endmodule
